// File: rtl/fir_seq_ctrl_if.sv
// Signal bundle between fir_seq_ctrl and the host, input memory, FIR filter and output memory.
interface fir_seq_ctrl_if #(
  parameter int unsigned N_TAP  = 5,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned DIN_W  = 8,
  parameter int unsigned DOUT_W = 22,
  parameter int unsigned ADDR_W = 8
);
  logic                     cfg_we;
  logic [2:0]               cfg_addr;
  logic [COEF_W-1:0]        cfg_data;
  logic                     start;
  logic                     pause;
  logic                     abort;
  logic                     busy;
  logic                     done;
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_rd_addr;
  logic [DIN_W-1:0]         mem_rd_data;
  logic                     fir_clr;
  logic                     fir_in_valid;
  logic [DIN_W-1:0]         fir_in;
  logic [N_TAP*COEF_W-1:0]  coef_flat;
  logic [DOUT_W-1:0]        fir_out;
  logic                     out_we;
  logic [ADDR_W-1:0]        out_addr;
  logic [DOUT_W-1:0]        out_data;

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, pause, abort, mem_rd_data, fir_out,
    output busy, done, mem_rd_en, mem_rd_addr, fir_clr, fir_in_valid, fir_in,
           coef_flat, out_we, out_addr, out_data
  );

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, pause, abort, mem_rd_data, fir_out,
    input  busy, done, mem_rd_en, mem_rd_addr, fir_clr, fir_in_valid, fir_in,
           coef_flat, out_we, out_addr, out_data
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequencer for the 5-tap FIR: coefficient banks, sample issue from input memory,
// latency tracking and result write-back with start/busy/done/abort handshake.
module fir_seq_ctrl #(
  parameter int unsigned N_TAP    = 5,
  parameter int unsigned COEF_W   = 12,
  parameter int unsigned DIN_W    = 8,
  parameter int unsigned DOUT_W   = 22,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned N_SAMPLE = 256,
  parameter int unsigned LAT      = 3
) (
  input  logic           clk,
  input  logic           rstn,
  fir_seq_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned COEF_FW = N_TAP * COEF_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [COEF_W-1:0]  r_shadow [N_TAP];
  logic [COEF_FW-1:0] r_coef;
  logic [COEF_FW-1:0] w_shadow_flat;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic               r_fiv;
  logic [LAT-1:0]     r_vsr;
  logic               r_fir_clr;
  logic               r_busy;
  logic               r_done;
  logic               w_accept;
  logic               w_issue;
  logic               w_abort;
  logic               w_out_we;
  logic               w_last_wr;

  assign w_out_we  = r_vsr[LAT-1];
  assign w_last_wr = w_out_we && (r_wr_cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-cycle strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = ~bus.pause;
        if (bus.abort) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_issue && (r_issue_cnt == LAST)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_last_wr) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_shadow_flat = '0;
    for (int i = 0; i < N_TAP; i++) w_shadow_flat[i*COEF_W +: COEF_W] = r_shadow[i];
  end

  // Shadow bank takes writes any time; active bank snapshots it only at start-accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_TAP; i++) r_shadow[i] <= '0;
      r_coef <= '0;
    end else begin
      if (bus.cfg_we && (32'(bus.cfg_addr) < N_TAP)) r_shadow[bus.cfg_addr] <= bus.cfg_data;
      if (w_accept) r_coef <= w_shadow_flat;
    end
  end

  // Counters, valid pipeline and registered handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
      r_fiv       <= 1'b0;
      r_vsr       <= '0;
      r_fir_clr   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_fir_clr <= w_accept;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_issue_cnt <= '0;
        r_wr_cnt    <= '0;
        r_fiv       <= 1'b0;
        r_vsr       <= '0;
      end else if (w_abort) begin
        r_fiv <= 1'b0;
        r_vsr <= '0;
      end else begin
        r_fiv <= w_issue;
        r_vsr <= LAT'({r_vsr, r_fiv});
        if (w_issue)  r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        if (w_out_we) r_wr_cnt    <= r_wr_cnt + CNT_W'(1);
      end
    end
  end

  // Data passes straight through, gated so idle/reset outputs read as zero
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.mem_rd_en    = w_issue;
  assign bus.mem_rd_addr  = r_issue_cnt[ADDR_W-1:0];
  assign bus.fir_clr      = r_fir_clr;
  assign bus.fir_in_valid = r_fiv;
  assign bus.fir_in       = r_fiv ? bus.mem_rd_data : '0;
  assign bus.coef_flat    = r_coef;
  assign bus.out_we       = w_out_we;
  assign bus.out_addr     = r_wr_cnt[ADDR_W-1:0];
  assign bus.out_data     = w_out_we ? bus.fir_out : '0;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: config vector table plus full, paused,
// aborted and reset-interrupted runs against memory and filter models.
module tb_fir_seq_ctrl;
  localparam int unsigned N_SAMPLE = 256;
  localparam int unsigned LAT      = 3;
  localparam int          BUDGET   = 600;

  localparam logic [59:0] C1 = 60'h652ca041dc9d25d;
  localparam logic [59:0] C2 = 60'h652ca041dc9d111;
  localparam logic [59:0] C3 = 60'h652ca041dc9d123;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fir_seq_ctrl_if u_if ();

  fir_seq_ctrl #(.N_SAMPLE(N_SAMPLE), .LAT(LAT)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if)
  );

  // Input memory holds mem[i] = i; filter model is a 3-deep pipe with a fixed mapping
  logic [7:0] p0, p1, p2;
  always @(posedge clk) begin
    if (u_if.mem_rd_en) u_if.mem_rd_data <= u_if.mem_rd_addr;
    p0 <= u_if.fir_in;
    p1 <= p0;
    p2 <= p1;
  end
  assign u_if.fir_out = {6'h2a, ~p2, p2};

  function automatic logic [21:0] fexp(input int k);
    logic [7:0] d;
    d = 8'(k);
    return {6'h2a, ~d, d};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl_zero"},
        64'({u_if.busy, u_if.done, u_if.mem_rd_en, u_if.mem_rd_addr, u_if.fir_clr,
             u_if.fir_in_valid, u_if.fir_in, u_if.out_we, u_if.out_addr, u_if.out_data}), 64'(0));
    chk({tag, "_coef_zero"}, 64'(u_if.coef_flat), 64'(0));
  endtask

  int clr_cnt, clr_cyc, n_iss, first_iss, last_iss, iss_bad, n_fin;
  int n_wr, wr_bad, we_first, we_last, done_cnt, done_cyc, busy_lo;
  int coef_bad, post_bad;
  logic busy_stop, stopped;

  // One run from start-accept; cycle t = t-th cycle after the accept edge
  task automatic do_run(input int p_lo, input int p_hi, input int abort_at, input int cfg_at,
                        input int stop_at, input logic [59:0] cf);
    clr_cnt = 0; clr_cyc = -1; n_iss = 0; first_iss = -1; last_iss = -1; iss_bad = 0; n_fin = 0;
    n_wr = 0; wr_bad = 0; we_first = -1; we_last = -1; done_cnt = 0; done_cyc = -1; busy_lo = -1;
    coef_bad = 0; post_bad = 0; busy_stop = 1'b1; stopped = 1'b0;
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    for (int t = 0; t < BUDGET; t++) begin
      u_if.pause    = (t >= p_lo) && (t < p_hi);
      u_if.abort    = (t == abort_at);
      u_if.cfg_we   = (t == cfg_at);
      u_if.cfg_addr = 3'd0;
      u_if.cfg_data = 12'h123;
      #1;
      if (u_if.fir_clr) begin clr_cnt++; clr_cyc = t; end
      if (u_if.mem_rd_en) begin
        if (u_if.mem_rd_addr !== 8'(n_iss)) iss_bad++;
        if (n_iss == 0) first_iss = t;
        last_iss = t;
        n_iss++;
      end
      if (u_if.fir_in_valid) begin
        if (u_if.fir_in !== 8'(n_fin)) iss_bad++;
        n_fin++;
      end
      if (u_if.out_we) begin
        if (u_if.out_addr !== 8'(n_wr) || u_if.out_data !== fexp(n_wr)) wr_bad++;
        if (n_wr == 0) we_first = t;
        we_last = t;
        n_wr++;
      end
      if (abort_at >= 0 && t > abort_at && (u_if.out_we || u_if.done)) post_bad++;
      if (u_if.done) begin done_cnt++; done_cyc = t; end
      if (u_if.coef_flat !== cf) coef_bad++;
      if (t == stop_at) begin busy_stop = u_if.busy; stopped = 1'b1; break; end
      if (done_cnt > 0 && !u_if.busy) begin busy_lo = t; stopped = 1'b1; break; end
      @(posedge clk); #1;
    end
    u_if.pause  = 1'b0;
    u_if.abort  = 1'b0;
    u_if.cfg_we = 1'b0;
  endtask

  task automatic check_full(input string tag, input int exp_last_iss, input int exp_done);
    chk({tag, "_finished"}, 64'(stopped), 64'(1));
    chk({tag, "_clr_cnt"}, 64'(clr_cnt), 64'(1));
    chk({tag, "_clr_cyc"}, 64'(clr_cyc), 64'(0));
    chk({tag, "_n_iss"}, 64'(n_iss), 64'(N_SAMPLE));
    chk({tag, "_first_iss"}, 64'(first_iss), 64'(0));
    chk({tag, "_last_iss"}, 64'(last_iss), 64'(exp_last_iss));
    chk({tag, "_iss_bad"}, 64'(iss_bad), 64'(0));
    chk({tag, "_n_fin"}, 64'(n_fin), 64'(N_SAMPLE));
    chk({tag, "_n_wr"}, 64'(n_wr), 64'(N_SAMPLE));
    chk({tag, "_wr_bad"}, 64'(wr_bad), 64'(0));
    chk({tag, "_we_first"}, 64'(we_first), 64'(LAT + 1));
    chk({tag, "_we_last"}, 64'(we_last), 64'(exp_done - 1));
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
    chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
    chk({tag, "_busy_lo"}, 64'(busy_lo), 64'(exp_done + 1));
    chk({tag, "_coef_bad"}, 64'(coef_bad), 64'(0));
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [11:0] data;
    logic        start;
    logic        abort;
    logic [59:0] coef;
    logic        busy;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{1'b1, 3'd0, 12'h25d, 1'b0, 1'b0, 60'h0, 1'b0};
    vt[1]  = '{1'b1, 3'd1, 12'hc9d, 1'b0, 1'b0, 60'h0, 1'b0};
    vt[2]  = '{1'b1, 3'd2, 12'h41d, 1'b0, 1'b0, 60'h0, 1'b0};
    vt[3]  = '{1'b1, 3'd3, 12'hca0, 1'b0, 1'b0, 60'h0, 1'b0};
    vt[4]  = '{1'b1, 3'd4, 12'h652, 1'b0, 1'b0, 60'h0, 1'b0};
    vt[5]  = '{1'b0, 3'd0, 12'h000, 1'b1, 1'b0, C1,    1'b1};
    vt[6]  = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, C1,    1'b0};
    vt[7]  = '{1'b1, 3'd5, 12'hfff, 1'b0, 1'b0, C1,    1'b0};
    vt[8]  = '{1'b1, 3'd0, 12'h111, 1'b1, 1'b0, C1,    1'b1};
    vt[9]  = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, C1,    1'b0};
    vt[10] = '{1'b0, 3'd0, 12'h000, 1'b1, 1'b0, C2,    1'b1};
    vt[11] = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, C2,    1'b0};

    u_if.cfg_we = 1'b0; u_if.cfg_addr = 3'd0; u_if.cfg_data = 12'h0;
    u_if.start = 1'b0; u_if.pause = 1'b0; u_if.abort = 1'b0;
    u_if.mem_rd_data = 8'h0;
    p0 = 8'h0; p1 = 8'h0; p2 = 8'h0;

    #12;
    chk_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Configuration and bank-copy behaviour
    for (int i = 0; i < 12; i++) begin
      u_if.cfg_we   = vt[i].we;
      u_if.cfg_addr = vt[i].addr;
      u_if.cfg_data = vt[i].data;
      u_if.start    = vt[i].start;
      u_if.abort    = vt[i].abort;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_coef", i), 64'(u_if.coef_flat), 64'(vt[i].coef));
      chk($sformatf("vec%0d_busy", i), 64'(u_if.busy), 64'(vt[i].busy));
    end
    u_if.cfg_we = 1'b0; u_if.start = 1'b0; u_if.abort = 1'b0;

    do_run(-1, -1, -1, -1, -1, C2);
    check_full("full", 255, 260);

    do_run(10, 20, -1, -1, -1, C2);
    check_full("pause", 265, 270);

    do_run(-1, -1, 100, -1, 101, C2);
    chk("abort_n_iss", 64'(n_iss), 64'(101));
    chk("abort_n_wr", 64'(n_wr), 64'(97));
    chk("abort_wr_bad", 64'(wr_bad), 64'(0));
    chk("abort_post", 64'(post_bad), 64'(0));
    chk("abort_done", 64'(done_cnt), 64'(0));
    chk("abort_busy", 64'(busy_stop), 64'(0));
    chk("abort_coef", 64'(u_if.coef_flat), 64'(C2));

    // Immediate restart, with a coefficient write in the middle of it
    do_run(-1, -1, -1, 50, -1, C2);
    check_full("restart", 255, 260);

    do_run(-1, -1, -1, -1, 258, C3);
    chk("cfgrun_coef_bad", 64'(coef_bad), 64'(0));
    chk("drain_we", 64'(u_if.out_we), 64'(1));
    chk("drain_busy", 64'(u_if.busy), 64'(1));
    #3;
    rstn = 1'b0;
    #1;
    chk_zero("async_rst");
    #1;
    rstn = 1'b1;

    do_run(-1, -1, -1, -1, -1, 60'h0);
    check_full("post_rst", 255, 260);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Sequencing controller for the 5-tap FIR datapath.
- Holds shadow and active coefficient banks.
- On start, streams N_SAMPLE input samples from the input memory into the filter.
- Tracks the filter's fixed pipeline latency and writes each filtered result to the output memory, with start/busy/done handshake and abort.
- Sits between the system host and the FIR filter instance plus its input and output memories.

Parameters:
N_TAP, 5, number of coefficients
COEF_W, 12, coefficient width
DIN_W, 8, input sample width
DOUT_W, 22, filter output width
ADDR_W, 8, memory address width
N_SAMPLE, 256, samples per run (≤ 2^ADDR_W)
LAT, 3, filter latency from fir_in_valid to matching fir_out (≥1)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
cfg_we  in  1  coefficient write strobe
cfg_addr  in  3  coefficient index
cfg_data  in  COEF_W  coefficient value
start  in  1  begin a run (sampled in IDLE only)
pause  in  1  suspend sample issue
abort  in  1  terminate run
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at run completion
mem_rd_en  out  1  input memory read enable
mem_rd_addr  out  ADDR_W  input memory address
mem_rd_data  in  DIN_W  input memory data, valid the cycle after mem_rd_en
fir_clr  out  1  clears filter delay line
fir_in_valid  out  1  sample valid to filter
fir_in  out  DIN_W  sample to filter
coef_flat  out  N_TAP*COEF_W  active coefficients, c0 in LSBs
fir_out  in  DOUT_W  filter result
out_we  out  1  output memory write enable
out_addr  out  ADDR_W  output memory address
out_data  out  DOUT_W  output memory data

Behaviour:
Reset (rstn=0, asynchronous):
- State IDLE.
- All outputs 0; shadow and active coefficients 0.
- Counters and valid shift register cleared.

Configuration:
- cfg_we writes cfg_data to shadow[cfg_addr] in any state.
- cfg_addr ≥ N_TAP is ignored.
- The active bank is copied from shadow only on the start-accept edge.
- Writes during a run do not affect coef_flat until the next start.
- A cfg write on the same edge as start-accept: the copy takes the pre-write shadow value.

States and transitions:
- IDLE:
  - start=1 → RUN.
  - abort ignored.
- RUN:
  - Each cycle with pause=0: mem_rd_en=1, mem_rd_addr=issue count, issue count +1.
  - With pause=1: mem_rd_en=0, no issue.
  - fir_clr=1 only in the first RUN cycle, regardless of pause.
  - After issue count reaches N_SAMPLE → DRAIN.
- DRAIN:
  - No issue.
  - Waits until write count = N_SAMPLE → DONE.
  - pause has no effect.
- DONE:
  - done=1 for exactly one cycle → IDLE.
  - start is ignored in this cycle.

Abort (RUN or DRAIN):
- Next state is IDLE.
- Valid shift register is flushed.
- No out_we after the abort edge.
- done is not asserted.
- Active coefficients are retained.

Datapath timing:
- fir_in_valid(t) = mem_rd_en(t-1); fir_in = mem_rd_data.
- LAT-deep valid shift register: out_we(t) = fir_in_valid(t-LAT).
- out_data = fir_out.
- out_addr = write count, incremented after each out_we.
- In-flight samples complete normally under pause.

Latency, no pause:
- With RUN entered at cycle 0, issue occupies cycles 0..N_SAMPLE-1.
- out_we is high in cycles LAT+1..N_SAMPLE+LAT.
- done is high in cycle N_SAMPLE+LAT+1.
- Defaults: done at cycle 260.

Boundary rules:
- Address counters do not wrap within a run.
- Counters reset to 0 at each start-accept.
- busy falls on the same edge done falls.
- Widths are fixed; there is no arithmetic on data, values pass through only.

Test Plan:
1. Reset then config: write 0x25d, 0xc9d, 0x41d, 0xca0, 0x652 to addresses 0..4, then start → coef_flat = {0x652, 0xca0, 0x41d, 0xc9d, 0x25d}; write to address 5 → no change.
2. Full run, no pause: input mem[i]=i → fir_clr in cycle 0; mem_rd_addr 0..255 in cycles 0..255; out_we in cycles 4..259 with out_addr 0..255 and out_data = fir_out; done single pulse at cycle 260; busy low at 261.
3. Pause: pause=1 for cycles 10..19 of RUN → issue stops after address 9 and resumes at 10; outputs for 7..9 still written; done delayed to cycle 270; all 256 writes in order.
4. Abort in RUN at address 100 → state IDLE next cycle, no further out_we, no done; an immediate restart rewrites addresses from 0 with fir_clr.
5. Config during run: write cfg_addr 0 = 0x123 mid-run → coef_flat unchanged until next start, then c0 = 0x123.
6. Async reset mid-DRAIN: rstn low between edges → all outputs 0 immediately; after release, start accepted normally.
